// File: rtl/myriadrf_rx_stream_pkg.sv
// Shared encodings for the MyriadRF receive path: bus select values,
// assembler states and the default sample width.
package myriadrf_rx_stream_pkg;

    localparam int unsigned DefaultSampleW = 12;

    localparam logic IqselI = 1'b0;
    localparam logic IqselQ = 1'b1;

    typedef enum logic {
        StIdle  = 1'b0,
        StHaveI = 1'b1
    } asm_state_e;

endpackage

// File: rtl/myriadrf_rx_stream_if.sv
// Valid/ready pair stream from the RX front end to the DSP/DMA fabric.
interface myriadrf_rx_stream_if
    import myriadrf_rx_stream_pkg::*;
#(
    parameter int unsigned DataW = 2 * DefaultSampleW
) ();

    logic [DataW-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/myriadrf_sfifo.sv
// Generic single-clock show-ahead FIFO; the head entry is visible on data_o
// whenever the FIFO is non-empty. Shared with the TX path.
module myriadrf_sfifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CntW'(DEPTH));
        do_pop   = pop_i & ~empty_o;
        // A full FIFO still accepts a write when a read frees a slot this cycle.
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        data_o   = empty_o ? '0 : mem_q[rd_ptr_q];
        count_o  = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/myriadrf_rx_stream.sv
// MyriadRF RX front end: registers the interleaved I/Q bus, assembles pairs
// with framing checks and buffers them onto a valid/ready stream.
module myriadrf_rx_stream
    import myriadrf_rx_stream_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = DefaultSampleW,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned FillW     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                iqswap_i,
    input  logic                stat_clr_i,
    input  logic [SAMPLE_W-1:0] rxd,
    input  logic                rxiqsel,
    myriadrf_rx_stream_if.master m,
    output logic [FillW-1:0]    fill_o,
    output logic                ovf_o,
    output logic [CNT_W-1:0]    ovf_cnt_o,
    output logic                sync_err_o,
    output logic [CNT_W-1:0]    sync_err_cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [SAMPLE_W-1:0]   rxd_q;
    logic                  iqsel_q;
    asm_state_e            state_q;
    logic [SAMPLE_W-1:0]   i_q;
    logic                  pair_done, sync_evt, ovf_evt, pop;
    logic                  full, empty;
    logic [2*SAMPLE_W-1:0] pair_word;
    logic                  ovf_q, ovf_d, sync_err_q, sync_err_d;
    logic [CNT_W-1:0]      ovf_cnt_q, ovf_cnt_d, sync_cnt_q, sync_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q   <= '0;
            iqsel_q <= IqselI;
        end else begin
            rxd_q   <= rxd;
            iqsel_q <= rxiqsel;
        end
    end

    // Every I (re)loads the holding register; every Q returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            i_q     <= '0;
        end else if (!en_i) begin
            state_q <= StIdle;
        end else if (iqsel_q == IqselI) begin
            state_q <= StHaveI;
            i_q     <= rxd_q;
        end else begin
            state_q <= StIdle;
        end
    end

    always_comb begin
        pair_done = en_i && (state_q == StHaveI) && (iqsel_q == IqselQ);
        sync_evt  = en_i && (((state_q == StIdle) && (iqsel_q == IqselQ)) ||
                             ((state_q == StHaveI) && (iqsel_q == IqselI)));
        pair_word = iqswap_i ? {rxd_q, i_q} : {i_q, rxd_q};
        pop       = m.m_valid & m.m_ready;
        ovf_evt   = pair_done & full & ~pop;
    end

    myriadrf_sfifo #(
        .WIDTH(2 * SAMPLE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (pair_done),
        .data_i (pair_word),
        .pop_i  (pop),
        .data_o (m.m_data),
        .full_o (full),
        .empty_o(empty),
        .count_o(fill_o)
    );

    assign m.m_valid = ~empty;

    always_comb begin
        ovf_d      = ovf_q;
        ovf_cnt_d  = ovf_cnt_q;
        sync_err_d = sync_err_q;
        sync_cnt_d = sync_cnt_q;
        if (stat_clr_i) begin
            ovf_d      = 1'b0;
            ovf_cnt_d  = '0;
            sync_err_d = 1'b0;
            sync_cnt_d = '0;
        end else begin
            if (ovf_evt) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != CntMax) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
            if (sync_evt) begin
                sync_err_d = 1'b1;
                if (sync_cnt_q != CntMax) sync_cnt_d = sync_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q      <= 1'b0;
            ovf_cnt_q  <= '0;
            sync_err_q <= 1'b0;
            sync_cnt_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
            sync_err_q <= sync_err_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    assign ovf_o          = ovf_q;
    assign ovf_cnt_o      = ovf_cnt_q;
    assign sync_err_o     = sync_err_q;
    assign sync_err_cnt_o = sync_cnt_q;

endmodule

// File: tb/tb_myriadrf_rx_stream.sv
// Bench for myriadrf_rx_stream: cycle-level reference model feeds a
// scoreboard queue, a negedge monitor compares the DUT against it.
module tb_myriadrf_rx_stream;

    localparam int SW = 12;
    localparam int FD = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          iqswap;
    logic          stat_clr;
    logic [SW-1:0] rxd;
    logic          rxiqsel;
    logic          m_ready;
    logic [3:0]    fill;
    logic          ovf, sync_err;
    logic [CW-1:0] ovf_cnt, sync_cnt;

    myriadrf_rx_stream_if #(.DataW(2 * SW)) m_if ();
    assign m_if.m_ready = m_ready;

    myriadrf_rx_stream #(
        .SAMPLE_W  (SW),
        .FIFO_DEPTH(FD),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .iqswap_i      (iqswap),
        .stat_clr_i    (stat_clr),
        .rxd           (rxd),
        .rxiqsel       (rxiqsel),
        .m             (m_if.master),
        .fill_o        (fill),
        .ovf_o         (ovf),
        .ovf_cnt_o     (ovf_cnt),
        .sync_err_o    (sync_err),
        .sync_err_cnt_o(sync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [2*SW-1:0] exp_q[$];
    int              mcnt = 0;
    int              ocnt = 0, scnt = 0;
    bit              oflag = 0, sflag = 0;
    bit              have = 0;
    logic [SW-1:0]   held = '0;
    logic [SW-1:0]   reg_d = '0;
    logic            reg_sel = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                mcnt = 0; ocnt = 0; scnt = 0; oflag = 0; sflag = 0;
                have = 0; held = '0; reg_d = '0; reg_sel = 1'b0;
            end else begin
                bit pop, done, err, drop;
                logic [2*SW-1:0] pw;
                pop = m_ready && (mcnt > 0);
                done = 0; err = 0; pw = '0;
                if (!en) begin
                    have = 0;
                end else if (have) begin
                    if (reg_sel) begin
                        done = 1;
                        pw = iqswap ? {reg_d, held} : {held, reg_d};
                        have = 0;
                    end else begin
                        err = 1;
                        held = reg_d;
                    end
                end else begin
                    if (!reg_sel) begin
                        held = reg_d;
                        have = 1;
                    end else begin
                        err = 1;
                    end
                end
                drop = done && (mcnt == FD) && !pop;
                if (done && !drop) exp_q.push_back(pw);
                mcnt = mcnt - int'(pop) + int'(done && !drop);
                if (stat_clr) begin
                    ocnt = 0; scnt = 0; oflag = 0; sflag = 0;
                end else begin
                    if (drop) begin oflag = 1; if (ocnt < CMAX) ocnt++; end
                    if (err)  begin sflag = 1; if (scnt < CMAX) scnt++; end
                end
                reg_d = rxd;
                reg_sel = rxiqsel;
            end
        end
    end

    // Monitor: outputs are settled at negedge; a transfer seen here completes
    // on the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("fill", fill, mcnt);
                check("valid", m_if.m_valid, mcnt != 0);
                check("ovf", ovf, oflag);
                check("ovf_cnt", ovf_cnt, ocnt);
                check("sync_err", sync_err, sflag);
                check("sync_cnt", sync_cnt, scnt);
                if (mcnt > 0 && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_empty", 1, 0);
                    end else begin
                        check("pair_data", m_if.m_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    logic [SW-1:0] bd[$];
    logic          bs[$];

    task automatic send(input logic [SW-1:0] d, input logic s);
        rxd = d;
        rxiqsel = s;
        @(posedge clk);
        #2;
    endtask

    task automatic add_pair(input logic [SW-1:0] i, input logic [SW-1:0] q);
        bd.push_back(i); bs.push_back(1'b0);
        bd.push_back(q); bs.push_back(1'b1);
    endtask

    // Enable tracks the registered sample: it rises one edge after the first
    // sample is driven and falls after the last one has been processed.
    task automatic run_burst();
        en = 1'b0;
        for (int k = 0; k < bd.size(); k++) begin
            send(bd[k], bs[k]);
            if (k == 0) en = 1'b1;
        end
        send('0, 1'b0);
        en = 1'b0;
        send('0, 1'b0);
        bd.delete();
        bs.delete();
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int k = 0; k < 40 && (mcnt != 0 || m_if.m_valid); k++) begin
            @(posedge clk);
            #2;
        end
        check("drain_done", m_if.m_valid, 1'b0);
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        send('0, 1'b0);
        stat_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; iqswap = 1'b0; stat_clr = 1'b0;
        rxd = '0; rxiqsel = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", m_if.m_valid, 1'b0);
        check("rst_fill", fill, 0);
        check("rst_data", m_if.m_data, 0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        check("rst_sync_err", sync_err, 1'b0);
        check("rst_sync_cnt", sync_cnt, 0);
        rst_n = 1'b1;
        send('0, 1'b0);

        // Two-edge latency: Q on the bus at E0, pair visible after E1.
        m_ready = 1'b0;
        send(12'h123, 1'b0);
        en = 1'b1;
        send(12'h456, 1'b1);
        #1;
        check("lat_before_e1", m_if.m_valid, 1'b0);
        #1;
        rxd = '0; rxiqsel = 1'b0;
        @(posedge clk);
        #1;
        check("lat_valid_e1", m_if.m_valid, 1'b1);
        check("lat_data_e1", m_if.m_data, 24'h123456);
        #1;
        en = 1'b0;
        send('0, 1'b0);
        drain();

        for (int k = 0; k < 10; k++) add_pair(12'h123, 12'h456);
        run_burst();
        drain();
        iqswap = 1'b1;
        m_ready = 1'b0;
        add_pair(12'h123, 12'h456);
        run_burst();
        check("swap_data", m_if.m_data, 24'h456123);
        for (int k = 0; k < 6; k++) add_pair(12'h123, 12'h456);
        m_ready = 1'b1;
        run_burst();
        drain();
        iqswap = 1'b0;
        check("clean_ovf_cnt", ovf_cnt, 0);
        check("clean_sync_cnt", sync_cnt, 0);

        // Backpressure: 20 pairs into an 8-deep FIFO.
        clear_stats();
        m_ready = 1'b0;
        for (int k = 0; k < 20; k++) add_pair(SW'(k), SW'(12'h100 + k));
        run_burst();
        check("bp_fill", fill, 8);
        check("bp_ovf", ovf, 1'b1);
        check("bp_ovf_cnt", ovf_cnt, 12);
        check("bp_head", m_if.m_data, 24'h000100);
        drain();

        // Framing: I1,I2,Q1,Q2,I3,Q3.
        clear_stats();
        m_ready = 1'b0;
        bd = '{12'h111, 12'h222, 12'hA01, 12'hA02, 12'h333, 12'hA03};
        bs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_burst();
        check("frm_sync_cnt", sync_cnt, 2);
        check("frm_sync_err", sync_err, 1'b1);
        check("frm_fill", fill, 2);
        check("frm_head", m_if.m_data, 24'h222A01);
        drain();

        // Saturation then clear.
        clear_stats();
        m_ready = 1'b0;
        for (int k = 0; k < FD + CMAX + 4; k++) add_pair(SW'(k), SW'(k + 1));
        run_burst();
        check("sat_ovf_cnt", ovf_cnt, CMAX);
        check("sat_fill", fill, FD);
        clear_stats();
        check("clr_ovf", ovf, 1'b0);
        check("clr_ovf_cnt", ovf_cnt, 0);
        check("clr_sync_err", sync_err, 1'b0);
        check("clr_sync_cnt", sync_cnt, 0);
        drain();

        // Enable drops between I and Q.
        m_ready = 1'b1;
        send(12'h7AB, 1'b0);
        en = 1'b1;
        send(12'h7CD, 1'b1);
        en = 1'b0;
        send('0, 1'b0);
        send('0, 1'b0);
        check("en_drop_fill", fill, 0);
        check("en_drop_valid", m_if.m_valid, 1'b0);
        check("en_drop_sync", sync_cnt, 0);

        // Randomised traffic.
        begin
            logic s;
            s = 1'b1;
            for (int seg = 0; seg < 6; seg++) begin
                en = 1'b0;
                stat_clr = 1'b0;
                send('0, 1'b0);
                iqswap = 1'($urandom_range(0, 1));
                send('0, 1'b0);
                for (int c = 0; c < 60; c++) begin
                    s = ~s;
                    if ($urandom_range(0, 9) == 0) s = ~s;
                    en = ($urandom_range(0, 19) != 0);
                    m_ready = ($urandom_range(0, 2) != 0);
                    stat_clr = ($urandom_range(0, 29) == 0);
                    send(SW'($urandom_range(0, 4095)), s);
                end
            end
            en = 1'b0;
            stat_clr = 1'b0;
            send('0, 1'b0);
            send('0, 1'b0);
            drain();
        end

        // Asynchronous reset with a partly filled FIFO.
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) add_pair(SW'(k + 3), SW'(k + 9));
        run_burst();
        check("pre_rst_fill", fill, 5);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", m_if.m_valid, 1'b0);
        check("async_rst_fill", fill, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send('0, 1'b0);
        send('0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/myriadrf_rx_stream.md
# myriadrf_rx_stream

Parametrised MyriadRF receive-path front end: registers the interleaved I/Q bus from the transceiver, assembles I/Q pairs with framing checks, optionally swaps I and Q, and buffers pairs in a small FIFO. The FIFO presents them on a valid/ready stream to the DSP/DMA fabric. It replaces the fixed 12-bit, unbuffered RX capture. Backpressure is absorbed up to FIFO_DEPTH pairs, and overflow and framing faults are reported instead of silently lost.

## Interface
- SAMPLE_W, 12: bits per I or Q sample on rxd.
- FIFO_DEPTH, 8: pair FIFO depth; power of two, ≥2.
- CNT_W, 16: width of the overflow and sync-error counters.

- clk  in  1  sample clock (same clock as the transceiver RX bus).
- rst_n  in  1  reset; asynchronous, active-low.
- en_i  in  1  capture enable; low discards incoming samples.
- iqswap_i  in  1  1 = output {Q,I} instead of {I,Q}; static while en_i=1.
- stat_clr_i  in  1  synchronous clear of ovf_o, sync_err_o and both counters.
- rxd  in  SAMPLE_W  transceiver sample bus.
- rxiqsel  in  1  0 = rxd carries I, 1 = rxd carries Q.
- m_data_o  out  2*SAMPLE_W  pair; default {I in upper half, Q in lower half}.
- m_valid_o  out  1  pair available.
- m_ready_i  in  1  consumer accepts pair when m_valid_o & m_ready_i.
- fill_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf_o  out  1  sticky: a completed pair was dropped because the FIFO was full.
- ovf_cnt_o  out  CNT_W  dropped-pair count; saturates at all-ones.
- sync_err_o  out  1  sticky: framing violation seen.
- sync_err_cnt_o  out  CNT_W  framing-violation count; saturates.

## Operation
- Input stage: rxd and rxiqsel are registered unconditionally every cycle (IOB-friendly). All further logic uses the registered copies.
- Assembler states:
  - IDLE (no I held).
  - HAVE_I (I held).
- Assembler transitions on each registered sample while en_i=1:
  - IDLE, iqsel=0: store I, go to HAVE_I.
  - IDLE, iqsel=1: orphan Q. Count one sync error, stay in IDLE.
  - HAVE_I, iqsel=1: pair complete. Write the pair to the FIFO, go to IDLE.
  - HAVE_I, iqsel=0: repeated I. Count one sync error, replace the held I, stay in HAVE_I.
- en_i=0: assembler is forced to IDLE and the held I is discarded. The FIFO keeps draining.
- Pair word:
  - iqswap_i=0: {I,Q}.
  - iqswap_i=1: {Q,I}.
  - The word is fixed at write time.
- Counters and sticky flags:
  - Overflow: a pair completes while the FIFO is full and no read happens in the same cycle. The pair is dropped, ovf_o is set, and ovf_cnt_o increments.
  - Full FIFO with a read in the same cycle: the write is accepted and occupancy is unchanged.
  - Both counters saturate at 2^CNT_W−1 and do not wrap.
  - stat_clr_i takes priority: an event in the same cycle as stat_clr_i is not counted, and flags/counters read 0 the next cycle.
- Reset values:
  - m_valid_o=0, fill_o=0, ovf_o=0, ovf_cnt_o=0, sync_err_o=0, sync_err_cnt_o=0, m_data_o=0.
  - Assembler in IDLE, input registers 0.
- Reset mid-operation empties the FIFO immediately, without waiting for a clock edge.

## Timing
- Latency: Q sample present on rxd at edge E0 → pair written at edge E1 → m_valid_o=1 and m_data_o valid after E1, if the FIFO was empty. That is 2 edges.
- FIFO is show-ahead:
  - m_valid_o = (fill_o≠0).
  - m_data_o shows the head entry and is stable while m_valid_o=1 and m_ready_i=0.
- Throughput: one pair per two clocks from the bus. The output sustains one pair per clock.
- fill_o, ovf_o and the counters update on the same edge as the causing event.
- en_i, iqswap_i and stat_clr_i act on the edge where they are sampled high.

## Structure
- Shared header myriadrf_defs.vh holds:
  - the IQSEL_I/IQSEL_Q encodings;
  - the assembler state encodings (IDLE, HAVE_I);
  - the default SAMPLE_W.
- Sub-module myriadrf_sfifo: generic single-clock show-ahead FIFO with parameters WIDTH and DEPTH. It has push/pop/full/empty/count ports and an asynchronous active-low reset. Reused by the TX path.
- Top level holds the input registers, assembler FSM and statistics.

## Test plan
- Alternating I=0x123/Q=0x456, m_ready_i=1, SAMPLE_W=12 → m_data_o=0x123456 valid 2 edges after the Q sample. One pair every 2 clocks, counters stay 0.
- Same stream with iqswap_i=1 → m_data_o=0x456123.
- m_ready_i=0 for 20 pairs, FIFO_DEPTH=8:
  - fill_o reaches 8;
  - ovf_o=1 and ovf_cnt_o=12;
  - on release, the first 8 pairs drain in order.
- Framing faults: sequence I,I,Q,Q,I,Q →
  - sync_err_cnt_o=2;
  - emitted pairs are {I2,Q1} then {I3,Q3}.
- Saturation and clear:
  - force 2^CNT_W+3 overflows (CNT_W=4) → ovf_cnt_o=0xF;
  - pulse stat_clr_i → all flags/counters 0 next cycle.
- Reset and enable:
  - assert rst_n=0 mid-stream with fill_o=5 → m_valid_o=0 and fill_o=0 without a clock edge;
  - en_i=0 between I and Q → the held I is discarded and no pair is produced.
